mem_access_unit: RTL

- MEM-stage producer feeding the MEM/WB pipeline register. It sits between EX/MEM and MEM/WB and drives the register's inputs: WB, MemRdata, ALUres, rd_addr and WBSrc.
- Runs loads and stores against a multi-cycle data memory using a req/ack handshake. It stalls the upstream pipeline and inserts WB=0 bubbles into MEM/WB until each access completes.
- Non-memory instructions pass through with zero added latency.

---
 rtl/mem_access_pkg.sv | 8 +
 rtl/sat_counter.sv | 18 +
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the MEM-stage access unit
package mem_access_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: 32-bit saturating event counter with enable and async active-low clear
module sat_counter
  import mem_access_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q, cnt_d;
  // increment while enabled, holding at the maximum instead of wrapping
  always_comb cnt_d = (en_i && cnt_q != STALL_CNT_MAX) ? cnt_q + 32'd1 : cnt_q;
  // counter register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer feeding MEM/WB; MEM_ALIGN_CHECK_EN enables misaligned-access trapping
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              WB_i,
  input  logic              WBSrc_i,
  input  logic [DATA_W-1:0] ALUres_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic              WB_o,
  output logic              WBSrc_o,
  output logic [DATA_W-1:0] ALUres_o,
  output logic [DATA_W-1:0] MemRdata_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o,
  output logic [31:0]       stall_cnt_o
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic wb_q, wb_d, wbsrc_q, wbsrc_d, we_q, we_d, mis_q, mis_d;
  logic mem_op, misalign;
  assign mem_op = MemRead_i | MemWrite_i;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ALUres_i[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif
  // state register; reset drops any in-flight request at once
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state_q <= IDLE;
    else state_q <= state_d;
  // next state: misaligned ops skip the request and report in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = misalign ? DONE : REQ;
      REQ:     if (mem_ack_i) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // capture the EX/MEM fields on issue and the read data on ack (stores keep 0)
  always_comb begin
    addr_d = addr_q;
    wdata_d = wdata_q;
    rd_d = rd_q;
    wb_d = wb_q;
    wbsrc_d = wbsrc_q;
    we_d = we_q;
    mis_d = mis_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && mem_op) begin
      addr_d = ALUres_i;
      wdata_d = wdata_i;
      rd_d = rd_addr_i;
      wb_d = WB_i;
      wbsrc_d = WBSrc_i;
      we_d = MemWrite_i;
      mis_d = misalign;
      rdata_d = '0;
    end
    if (state_q == REQ && mem_ack_i) rdata_d = we_q ? '0 : mem_rdata_i;
  end
  // latched access fields
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      wb_q <= 1'b0;
      wbsrc_q <= 1'b0;
      we_q <= 1'b0;
      mis_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      wb_q <= wb_d;
      wbsrc_q <= wbsrc_d;
      we_q <= we_d;
      mis_q <= mis_d;
      rdata_q <= rdata_d;
    end
  // outputs: pass-through in IDLE, bubble while busy, latched result in DONE
  always_comb begin
    WB_o = 1'b0;
    WBSrc_o = WBSrc_i;
    ALUres_o = ALUres_i;
    MemRdata_o = '0;
    rd_addr_o = rd_addr_i;
    stall_o = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    err_o = 1'b0;
    case (state_q)
      IDLE: begin
        WB_o = WB_i & ~mem_op & rst_i;
        stall_o = mem_op & rst_i;
      end
      REQ: begin
        WBSrc_o = wbsrc_q;
        ALUres_o = addr_q;
        rd_addr_o = rd_q;
        stall_o = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o = we_q;
      end
      DONE: begin
        WB_o = wb_q & ~mis_q;
        WBSrc_o = wbsrc_q;
        ALUres_o = addr_q;
        MemRdata_o = rdata_q;
        rd_addr_o = rd_q;
        err_o = mis_q;
      end
      default: ;
    endcase
  end
  assign mem_addr_o = ADDR_W'(addr_q);
  assign mem_wdata_o = wdata_q;
  sat_counter u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (stall_o),
    .cnt_o  (stall_cnt_o)
  );
endmodule
